// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit.
// Radix-2 shift-add multiply, restoring shift-subtract divide, sign fixup
// at the end. start/busy/done handshake, kill abort, global enable stall.
module muldiv_unit #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_hi;      // product high half / partial remainder
    logic [DATA_W-1:0]   r_lo;      // multiplier or dividend shifting out, product low / quotient shifting in
    logic [DATA_W-1:0]   r_b;       // multiplicand magnitude or divisor magnitude
    logic                r_sign;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_result;

    // ---- PREP: signedness, signs, magnitudes, special cases ----
    // r_lo holds raw operand_a and r_b raw operand_b while in PREP.
    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_sign;
    logic [DATA_W-1:0] w_mag_a, w_mag_b;
    logic              w_div0, w_ovf, w_special;
    logic [DATA_W-1:0] w_special_res;

    assign w_a_signed = r_op[2] ? ~r_op[0] : (r_op != 3'b011);
    assign w_b_signed = r_op[2] ? ~r_op[0] : ~r_op[1];
    assign w_a_neg    = w_a_signed & r_lo[DATA_W-1];
    assign w_b_neg    = w_b_signed & r_b[DATA_W-1];
    assign w_mag_a    = w_a_neg ? -r_lo : r_lo;
    assign w_mag_b    = w_b_neg ? -r_b : r_b;
    // Remainders take the dividend's sign; everything else the XOR.
    assign w_sign     = (r_op[2] & r_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0        = (r_b == '0);
    assign w_ovf         = ~r_op[0] & (r_lo == {1'b1, {(DATA_W-1){1'b0}}}) & (&r_b);
    assign w_special     = r_op[2] & (w_div0 | w_ovf);
    assign w_special_res = w_div0 ? (r_op[1] ? r_lo : {DATA_W{1'b1}})
                                  : (r_op[1] ? {DATA_W{1'b0}} : r_lo);

    // ---- CALC step datapath ----
    logic [DATA_W:0] w_msum, w_dsh, w_ddiff;
    logic            w_dge;

    assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
    assign w_dsh   = {r_hi, r_lo[DATA_W-1]};
    assign w_ddiff = w_dsh - {1'b0, r_b};
    assign w_dge   = ~w_ddiff[DATA_W];

    // ---- FIX: sign correction and result select ----
    logic [2*DATA_W-1:0] w_prod, w_prod_s;
    logic [DATA_W-1:0]   w_quo_s, w_rem_s, w_fix_res;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_sign ? -w_prod : w_prod;
    assign w_quo_s  = r_sign ? -r_lo : r_lo;
    assign w_rem_s  = r_sign ? -r_hi : r_hi;

    // Pick the slice of the corrected value that the opcode asks for.
    always_comb begin
        w_fix_res = w_prod_s[DATA_W-1:0];
        case (r_op)
            3'b000:                 w_fix_res = w_prod_s[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         w_fix_res = w_quo_s;
            default:                w_fix_res = w_rem_s;
        endcase
    end

    // FSM and datapath: reset first, everything frozen while enable is low,
    // kill beats every state transition including acceptance.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (enable) begin
            if (kill) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_op    <= op;
                            r_lo    <= operand_a;
                            r_b     <= operand_b;
                            r_hi    <= '0;
                            r_state <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        r_sign <= w_sign;
                        r_cnt  <= CNT_W'(DATA_W-1);
                        r_hi   <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            // Multiply walks the multiplier (b) through r_lo;
                            // divide walks the dividend (a) through r_lo.
                            if (r_op[2]) begin
                                r_lo <= w_mag_a;
                                r_b  <= w_mag_b;
                            end else begin
                                r_lo <= w_mag_b;
                                r_b  <= w_mag_a;
                            end
                            r_state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        if (r_op[2]) begin
                            r_hi <= w_dge ? w_ddiff[DATA_W-1:0] : w_dsh[DATA_W-1:0];
                            r_lo <= {r_lo[DATA_W-2:0], w_dge};
                        end else begin
                            r_hi <= w_msum[DATA_W:1];
                            r_lo <= {w_msum[0], r_lo[DATA_W-1:1]};
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_result <= w_fix_res;
                        r_state  <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and scoreboard check of muldiv_unit at DATA_W=64.
module tb_muldiv_unit;

    localparam int W = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MN   = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          arst_n, enable, start, kill;
    logic [2:0]    op;
    logic [W-1:0]  operand_a, operand_b;
    logic          busy, done;
    logic [W-1:0]  result;

    muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .start(start), .kill(kill),
        .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model built on 128-bit products and SV's truncating division.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       ea, eb, p;
        logic signed [63:0] sa, sb;
        logic [63:0]        r;
        sa = a; sb = b;
        ea = (o == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
        eb = o[1] ? {64'b0, b} : {{64{b[63]}}, b};
        p  = ea * eb;
        case (o)
            3'd0:             r = p[63:0];
            3'd1, 3'd2, 3'd3: r = p[127:64];
            3'd4: r = (b == 0) ? ONES : ((a == MN && b == ONES) ? a : 64'(sa / sb));
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: r = (b == 0) ? a : ((a == MN && b == ONES) ? 64'd0 : 64'(sa % sb));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == MN && b == ONES))) return 1;
        return W + 2;
    endfunction

    function automatic void add(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // One operation: accept, scramble inputs, wait for done, check latency/busy/result.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input string tag);
        int   n;
        logic bz_ok;
        logic [63:0] e;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; op = ~o; operand_a = ~a; operand_b = ~b;
        n = 0; bz_ok = 1'b1;
        while (!done && n < 200) begin
            if (!busy) bz_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy"}, 64'(bz_ok), 64'd1);
        e = sb_q.pop_front();
        check({tag, " result"}, result, e);
        last_exp = e;
        @(negedge clk);
        check({tag, " done falls"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        saw;
        logic [2:0]  o;
        logic [63:0] a, b, e;

        arst_n = 1'b0; enable = 1'b1; start = 1'b0; kill = 1'b0;
        op = '0; operand_a = '0; operand_b = '0; last_exp = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("reset outputs", {62'd0, busy, done}, 64'd0);
        check("reset result", result, 64'd0);
        arst_n = 1'b1;

        // directed vectors
        add(3'b000, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 66);
        add(3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        add(3'b001, ONES, ONES, 64'd0, 66);
        add(3'b010, ONES, 64'd2, ONES, 66);
        add(3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        add(3'b110, -64'sd7, 64'd2, ONES, 66);
        add(3'b101, 64'd100, 64'd7, 64'd14, 66);
        add(3'b111, 64'd100, 64'd7, 64'd2, 66);
        add(3'b100, 64'd5, 64'd0, ONES, 1);
        add(3'b110, 64'd5, 64'd0, 64'd5, 1);
        add(3'b101, 64'd5, 64'd0, ONES, 1);
        add(3'b111, 64'd5, 64'd0, 64'd5, 1);
        add(3'b100, MN, ONES, MN, 1);
        add(3'b110, MN, ONES, 64'd0, 1);
        add(3'b101, MN, ONES, 64'd0, 66);
        add(3'b111, MN, ONES, MN, 66);
        add(3'b100, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        add(3'b110, 64'd7, -64'sd2, 64'd1, 66);
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        // random operations against the model
        for (int i = 0; i < 12; i++) begin
            o = 3'(i % 8);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (o[2] && i >= 8) b = b >> $urandom_range(20, 60);
            run_op(o, a, b, model(o, a, b), lat_of(o, a, b), $sformatf("rnd%0d", i));
        end

        // kill 10 cycles into a DIVU
        @(negedge clk);
        op = 3'b101; operand_a = 64'd1000; operand_b = 64'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill idle", {62'd0, busy, done}, 64'd0);
        check("kill result kept", result, last_exp);
        saw = 1'b0;
        repeat (3) begin @(negedge clk); if (done || busy) saw = 1'b1; end
        check("kill no restart", 64'(saw), 64'd0);
        run_op(3'b101, 64'd1000, 64'd3, 64'd333, 66, "after kill");

        // kill and start together in IDLE
        @(negedge clk);
        op = 3'b000; operand_a = 64'd9; operand_b = 64'd9; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill beats start", 64'(busy), 64'd0);

        // stall mid-CALC and in DONE, with start pulses while busy
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        op = 3'b001; operand_a = a; operand_b = b; start = 1'b1;
        sb_q.push_back(model(3'b001, a, b));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            start = (n == 5 || n == 40);
            op = 3'b111; operand_a = 64'd77; operand_b = 64'd5;
            enable = !(n >= 20 && n < 25);
            @(negedge clk);
            n++;
        end
        start = 1'b0; enable = 1'b1;
        check("stall latency", 64'(n), 64'd71);
        enable = 1'b0;
        saw = 1'b1;
        repeat (5) begin @(negedge clk); if (!done || !busy) saw = 1'b0; end
        check("done held in stall", 64'(saw), 64'd1);
        e = sb_q.pop_front();
        check("stall result", result, e);
        enable = 1'b1;
        @(negedge clk);
        check("stall done falls", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        check("ignored start no op", 64'(busy), 64'd0);

        // reset in the middle of a MUL
        @(negedge clk);
        op = 3'b000; operand_a = 64'd12345; operand_b = 64'd678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        check("mid reset outputs", {62'd0, busy, done}, 64'd0);
        check("mid reset result", result, 64'd0);
        arst_n = 1'b1;
        run_op(3'b000, 64'd12345, 64'd678, 64'd8369910, 66, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV64 pipeline's EX stage, parametrised in `DATA_W`. It implements all eight RV M-extension operations with funct3 encoding:

- multiplication by radix-2 shift-add;
- division by restoring shift-subtract.

It replaces single-cycle multiplication in the ALU with a start/busy/done handshake that the hazard logic stalls on. It also provides a `kill` input so a branch/jump flush can abandon an operation in flight.

## Interface

Parameters:
- `DATA_W`, default 64: operand and result width. Must be even and ≥ 8.

Ports:
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `arst_n` input, 1 bit: reset, synchronous and active-low.
- `enable` input, 1 bit: global run enable. When low, all state, counters and outputs hold.
- `start` input, 1 bit: request a new operation. Sampled only in IDLE with `enable`=1.
- `kill` input, 1 bit: abort the current operation.
- `op` input, 3 bits: funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `operand_a` input, `DATA_W` bits: rs1 (multiplicand / dividend).
- `operand_b` input, `DATA_W` bits: rs2 (multiplier / divisor).
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse; `result` is valid in that cycle.
- `result` output, `DATA_W` bits: registered result. Holds its last value until the next `done`.

## Operation

Operand capture:
- `op`, `operand_a` and `operand_b` are captured at the accepting edge.
- Later changes on these inputs have no effect.

FSM states: IDLE, PREP, CALC, FIX, DONE.

IDLE:
- `start`=1 and `kill`=0: capture, go to PREP.
- Otherwise stay.

PREP (1 cycle):
- Record result sign.
  - MUL/MULH: sign = a_sign XOR b_sign.
  - MULHSU: sign = a_sign; b is treated as unsigned.
  - DIV: quotient sign = a_sign XOR b_sign.
  - REM: remainder sign = a_sign.
  - Unsigned ops: sign = 0.
- Replace signed operands by their magnitudes.
- Load the step counter with `DATA_W`-1.
- Special cases go straight to DONE and load `result` directly:
  - Divide by zero (`operand_b`=0): DIV/DIVU give all-ones; REM/REMU give `operand_a`.
  - Signed overflow (DIV/REM with a = most-negative and b = −1): DIV gives a; REM gives 0.
- All other cases go to CALC.

CALC (`DATA_W` cycles):
- Multiply: a 2·`DATA_W` accumulator adds the shifted multiplicand when the current multiplier bit is 1.
- Divide: shift a 1 bit into the partial remainder; subtract the divisor if the result is non-negative; shift the quotient bit in.
- Counter reaches 0: go to FIX.

FIX (1 cycle):
- Negate the 2·`DATA_W` product, quotient or remainder if sign=1 (two's complement, truncated to width).
- Select the result:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Write `result`, go to DONE.

DONE (1 cycle):
- `done`=1, then go to IDLE.
- `start` is not sampled in DONE; back-to-back operations need IDLE for at least 1 cycle.

`kill`:
- Effective only with `enable`=1.
- In any state it forces IDLE at the next edge.
- Suppresses `done` and leaves `result` unchanged.
- `kill` and `start` together in IDLE: `kill` wins, nothing is accepted.

`start` while `busy`=1 is ignored; no queueing.

Arithmetic:
- All arithmetic is modular to the stated widths.
- Remainder magnitude is always less than the divisor magnitude.
- Quotient rounds toward zero, per the RISC-V specification.

## Timing

Reset (`arst_n`=0 at a rising edge):
- State = IDLE; `busy`=0, `done`=0, `result`=0; counter and datapath registers = 0.
- This applies mid-operation as well; there is no output pulse.
- `arst_n` has priority over `kill`, `enable` and `start`.

Latency (start-accept edge = edge 0; all `enable`=1 cycles):
- Normal operations: `done` is high in the cycle after edge `DATA_W`+2, i.e. `DATA_W`+3 cycles including DONE. At `DATA_W`=64 that is 67 cycles.
- Special cases: `done` is high in the cycle after edge 1.
- `busy` rises the cycle after edge 0 and falls the cycle after `done`.

`enable`=0 cycles:
- Stretch latency 1:1 and freeze the counter.
- A `done` cycle held by `enable`=0 stays high until `enable` returns, so a stalled pipeline cannot miss it.

Throughput: one operation per `DATA_W`+4 cycles.

## Test plan

All scenarios use `DATA_W`=64.

- **MUL:** `op`=000, a=3, b=−5. Expect `result`=0xFFFF_FFFF_FFFF_FFF1, with `done` 67 cycles after the start edge; `busy` is high throughout.
- **MULHU / MULH:** MULHU with a=b=0xFFFF_FFFF_FFFF_FFFF gives 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands gives 0. MULHSU with a=−1, b=2 gives 0xFFFF_FFFF_FFFF_FFFF.
- **Signed/unsigned divide:**
  - DIV −7/2 gives 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 gives 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
- **Special cases:** each gives `done` 2 cycles after start, with no CALC cycles.
  - DIV 5/0 gives all-ones; REM 5/0 gives 5.
  - DIV 0x8000_0000_0000_0000 / −1 gives 0x8000_0000_0000_0000; REM gives 0.
- **Abort:** `kill` pulse 10 cycles into a DIVU goes to IDLE next cycle with no `done` and `result` unchanged. A new start 1 cycle later completes correctly. `arst_n`=0 mid-MUL gives all outputs 0 at the next edge.
- **Stall and ignored start:** `enable` low for 5 cycles mid-CALC and during DONE extends latency by exactly those cycles and keeps `done` high while stalled. `start` pulses while busy are ignored and the first operation's result is correct.
